// File: rtl/user_wb_counter_pkg.sv
// Shared definitions for the Wishbone counter peripheral.
// Holds register byte offsets, CTRL bit positions, the bus FSM state type
// and a byte-lane merge helper used for partial (wbs_sel_i) writes.
package user_wb_counter_pkg;

   localparam int unsigned WB_DW    = 32;
   localparam int unsigned WB_SEL_W = 4;
   localparam int unsigned OFS_W    = 4;

   // Register byte offsets within the 16-byte window
   localparam logic [OFS_W-1:0] REG_CTRL   = 4'h0;
   localparam logic [OFS_W-1:0] REG_COUNT  = 4'h4;
   localparam logic [OFS_W-1:0] REG_RELOAD = 4'h8;
   localparam logic [OFS_W-1:0] REG_STATUS = 4'hC;

   // CTRL register bit positions
   localparam int unsigned CTRL_W          = 4;
   localparam int unsigned CTRL_EN         = 0;
   localparam int unsigned CTRL_DIR        = 1;
   localparam int unsigned CTRL_AUTORELOAD = 2;
   localparam int unsigned CTRL_IRQ_EN     = 3;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } bus_state_e;

   // Replace only the byte lanes selected by sel; other lanes keep cur
   function automatic logic [WB_DW-1:0] byte_merge(input logic [WB_DW-1:0]    cur,
                                                   input logic [WB_DW-1:0]    wdata,
                                                   input logic [WB_SEL_W-1:0] sel);
      logic [WB_DW-1:0] res;
      res = cur;
      for (int b = 0; b < WB_SEL_W; b++) begin
         if (sel[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/user_wb_counter_core.sv
// Counter datapath: CTRL/COUNT/RELOAD registers, compare, reload and the
// sticky match flag. Bus writes arrive as load strobes with their values.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   ctrl_load/ctrl_value          CTRL register write
//   count_load/count_value        COUNT register write (beats the step)
//   reload_load/reload_value      RELOAD register write
//   match_clear                   STATUS.match write-1-to-clear
//   ctrl, count, reload, match    current register values
module user_wb_counter_core
   import user_wb_counter_pkg::*;
#(
   parameter int unsigned BITS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ctrl_load,
   input  logic [CTRL_W-1:0] ctrl_value,
   input  logic              count_load,
   input  logic [BITS-1:0]   count_value,
   input  logic              reload_load,
   input  logic [BITS-1:0]   reload_value,
   input  logic              match_clear,
   output logic [CTRL_W-1:0] ctrl,
   output logic [BITS-1:0]   count,
   output logic [BITS-1:0]   reload,
   output logic              match
);

   logic [CTRL_W-1:0] ctrl_next;
   logic [BITS-1:0]   count_next;
   logic              match_set;

   // Step / terminal-count evaluation for the current cycle
   always_comb begin
      ctrl_next  = ctrl;
      count_next = count;
      match_set  = 1'b0;
      if (ctrl[CTRL_EN]) begin
         if (!ctrl[CTRL_DIR]) begin
            if (count == reload) begin
               match_set = 1'b1;
               if (ctrl[CTRL_AUTORELOAD]) count_next = '0;
               else                       ctrl_next[CTRL_EN] = 1'b0;
            end else begin
               count_next = count + BITS'(1);
            end
         end else begin
            if (count == '0) begin
               match_set = 1'b1;
               if (ctrl[CTRL_AUTORELOAD]) count_next = reload;
               else                       ctrl_next[CTRL_EN] = 1'b0;
            end else begin
               count_next = count - BITS'(1);
            end
         end
      end
   end

   // Bus loads override the counter's own update; a match set beats a clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl   <= '0;
         count  <= '0;
         reload <= '0;
         match  <= 1'b0;
      end else begin
         ctrl  <= ctrl_load  ? ctrl_value  : ctrl_next;
         count <= count_load ? count_value : count_next;
         if (reload_load) reload <= reload_value;
         if (match_set)        match <= 1'b1;
         else if (match_clear) match <= 1'b0;
      end
   end

endmodule

// File: rtl/user_wb_counter.sv
// Wishbone classic slave wrapping the counter core. Decodes a 16-byte
// window at ADDR_BASE, acks every hit one cycle later for exactly one cycle,
// and drives count[15:0] onto mprj_io[31:16].
// Ports:
//   wb_clk_i, wb_rstn_i           clock, async active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i  Wishbone request
//   wbs_ack_o, wbs_dat_o          Wishbone response (read data held)
//   io_out, io_oeb                user pads; only [31:16] are driven
//   irq                           irq[0] = match & irq_en
module user_wb_counter
   import user_wb_counter_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
   parameter int unsigned BITS      = 32
) (
   input  logic                wb_clk_i,
   input  logic                wb_rstn_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_we_i,
   input  logic [WB_SEL_W-1:0] wbs_sel_i,
   input  logic [WB_DW-1:0]    wbs_adr_i,
   input  logic [WB_DW-1:0]    wbs_dat_i,
   output logic                wbs_ack_o,
   output logic [WB_DW-1:0]    wbs_dat_o,
   output logic [37:0]         io_out,
   output logic [37:0]         io_oeb,
   output logic [2:0]          irq
);

   bus_state_e        state, state_next;
   logic              hit, access, wr;
   logic [OFS_W-1:0]  offset;
   logic [WB_DW-1:0]  rd_value, wr_value;
   logic [CTRL_W-1:0] ctrl;
   logic [BITS-1:0]   count, reload;
   logic              match;
   logic              unused_bits;

   assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
   assign offset = {wbs_adr_i[3:2], 2'b00};

   // Bus FSM state register
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) state <= IDLE;
      else            state <= state_next;
   end

   // Accept a hit only from IDLE, so a held stb cannot re-trigger in ACK
   always_comb begin
      state_next = state;
      access     = 1'b0;
      case (state)
         IDLE: begin
            if (hit) begin
               state_next = ACK;
               access     = 1'b1;
            end
         end
         ACK: state_next = IDLE;
      endcase
   end

   assign wbs_ack_o = (state == ACK);
   assign wr        = access & wbs_we_i;

   // Register read mux, zero-extended to the bus width
   always_comb begin
      rd_value = '0;
      case (offset)
         REG_CTRL:   rd_value = WB_DW'(ctrl);
         REG_COUNT:  rd_value = WB_DW'(count);
         REG_RELOAD: rd_value = WB_DW'(reload);
         REG_STATUS: rd_value = WB_DW'(match);
         default:    rd_value = '0;
      endcase
   end

   assign wr_value = byte_merge(rd_value, wbs_dat_i, wbs_sel_i);

   // Read data captured on the accepting edge and held until the next read
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i)              wbs_dat_o <= '0;
      else if (access & ~wbs_we_i) wbs_dat_o <= rd_value;
   end

   user_wb_counter_core #(
      .BITS (BITS)
   ) u_core (
      .clk          (wb_clk_i),
      .rst_n        (wb_rstn_i),
      .ctrl_load    (wr && (offset == REG_CTRL)),
      .ctrl_value   (CTRL_W'(wr_value)),
      .count_load   (wr && (offset == REG_COUNT)),
      .count_value  (BITS'(wr_value)),
      .reload_load  (wr && (offset == REG_RELOAD)),
      .reload_value (BITS'(wr_value)),
      .match_clear  (wr && (offset == REG_STATUS) && wbs_sel_i[0] && wbs_dat_i[0]),
      .ctrl         (ctrl),
      .count        (count),
      .reload       (reload),
      .match        (match)
   );

   assign io_out = {6'b0, count[15:0], 16'b0};
   assign io_oeb = {6'h3F, 16'h0000, 16'hFFFF};
   assign irq    = {2'b00, match & ctrl[CTRL_IRQ_EN]};

   // Byte-address bits below the word and truncated write bits are don't-care
   assign unused_bits = ^{wbs_adr_i[1:0], wr_value};

endmodule

// File: tb/tb_user_wb_counter.sv
// Self-checking bench for user_wb_counter: directed scenarios from the test
// plan plus a randomized bus sweep against a register-level reference model.
module tb_user_wb_counter;

   localparam logic [31:0] BASE     = 32'h3000_0000;
   localparam logic [31:0] A_CTRL   = 32'h3000_0000;
   localparam logic [31:0] A_COUNT  = 32'h3000_0004;
   localparam logic [31:0] A_RELOAD = 32'h3000_0008;
   localparam logic [31:0] A_STATUS = 32'h3000_000C;

   logic        wb_clk_i  = 1'b0;
   logic        wb_rstn_i = 1'b0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_we_i  = 1'b0;
   logic [3:0]  wbs_sel_i = 4'h0;
   logic [31:0] wbs_adr_i = 32'h0;
   logic [31:0] wbs_dat_i = 32'h0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [37:0] io_out, io_oeb;
   logic [2:0]  irq;

   int checks = 0;
   int errors = 0;

   user_wb_counter dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rstn_i (wb_rstn_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .io_out    (io_out),
      .io_oeb    (io_oeb),
      .irq       (irq)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // ---------------- reference model (register level) ----------------
   logic [3:0]  m_ctrl;
   logic [31:0] m_count, m_reload, m_dat;
   logic        m_match, m_busy;
   logic        t_hit, t_set;
   logic [1:0]  t_idx;
   logic [3:0]  t_ctrl;
   logic [31:0] t_count, t_wd;

   function automatic logic [31:0] m_read(input logic [1:0] idx);
      case (idx)
         2'd0:    return {28'd0, m_ctrl};
         2'd1:    return m_count;
         2'd2:    return m_reload;
         default: return {31'd0, m_match};
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   always @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         m_ctrl = 4'h0; m_count = 32'h0; m_reload = 32'h0;
         m_match = 1'b0; m_busy = 1'b0; m_dat = 32'h0;
      end else begin
         t_hit  = !m_busy && wbs_cyc_i && wbs_stb_i && ((wbs_adr_i & 32'hFFFF_FFF0) == BASE);
         t_idx  = wbs_adr_i[3:2];
         t_ctrl = m_ctrl;
         t_count = m_count;
         t_set  = 1'b0;
         if (m_ctrl[0]) begin
            if (!m_ctrl[1]) begin
               if (m_count == m_reload) begin
                  t_set = 1'b1;
                  if (m_ctrl[2]) t_count = 32'h0; else t_ctrl[0] = 1'b0;
               end else t_count = m_count + 32'd1;
            end else begin
               if (m_count == 32'h0) begin
                  t_set = 1'b1;
                  if (m_ctrl[2]) t_count = m_reload; else t_ctrl[0] = 1'b0;
               end else t_count = m_count - 32'd1;
            end
         end
         if (t_hit && !wbs_we_i) m_dat = m_read(t_idx);
         if (t_hit && wbs_we_i) begin
            t_wd = merge(m_read(t_idx), wbs_dat_i, wbs_sel_i);
            case (t_idx)
               2'd0: t_ctrl = t_wd[3:0];
               2'd1: t_count = t_wd;
               2'd2: m_reload = t_wd;
               default: if (wbs_sel_i[0] && wbs_dat_i[0]) m_match = 1'b0;
            endcase
         end
         if (t_set) m_match = 1'b1;
         m_ctrl  = t_ctrl;
         m_count = t_count;
         m_busy  = t_hit;
      end
   end

   // ---------------- bus drivers ----------------
   task automatic bus_idle();
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
   endtask

   // Called #1 after a rising edge; returns #1 after the edge following the ack
   task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic w, output logic ack_seen, output logic [31:0] rd);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
      wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
      @(posedge wb_clk_i); #1;
      ack_seen = wbs_ack_o;
      rd = wbs_dat_o;
      bus_idle();
      @(posedge wb_clk_i); #1;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      logic ak; logic [31:0] r;
      wb_access(a, d, 4'hF, 1'b1, ak, r);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      logic ak;
      wb_access(a, 32'h0, 4'hF, 1'b0, ak, d);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] r;
      repeat (3) @(posedge wb_clk_i);
      #1;
      checks++;
      if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || io_out !== 38'h0) begin
         errors++;
         $display("FAIL reset_hold: ack=%b dat=%h io_out=%h expected 0/0/0", wbs_ack_o, wbs_dat_o, io_out);
      end
      @(negedge wb_clk_i); wb_rstn_i = 1'b1;
      @(posedge wb_clk_i); #1;
      // make irq and io_out non-zero so the async reset has something to clear
      wb_write(A_RELOAD, 32'h1234);
      wb_write(A_COUNT, 32'h1234);
      wb_write(A_CTRL, 32'h9);
      checks++;
      if (irq !== 3'b001) begin
         errors++; $display("FAIL pre_reset_irq: got %b expected 001", irq);
      end
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = A_COUNT; wbs_dat_i = 32'h5555; wbs_sel_i = 4'hF;
      @(posedge wb_clk_i); #2;
      checks++;
      if (wbs_ack_o !== 1'b1) begin
         errors++; $display("FAIL pre_reset_ack: got %b expected 1", wbs_ack_o);
      end
      wb_rstn_i = 1'b0;
      #1;
      checks++;
      if (wbs_ack_o !== 1'b0 || irq !== 3'b000 || io_out !== 38'h0) begin
         errors++;
         $display("FAIL async_reset: ack=%b irq=%b io_out=%h expected 0/000/0", wbs_ack_o, irq, io_out);
      end
      bus_idle();
      @(negedge wb_clk_i); wb_rstn_i = 1'b1;
      @(posedge wb_clk_i); #1;
      for (int i = 0; i < 4; i++) begin
         wb_read(BASE + 32'(4 * i), r);
         checks++;
         if (r !== 32'h0) begin
            errors++; $display("FAIL reset_reg%0d: got %h expected 00000000", i, r);
         end
      end
      checks++;
      if (io_oeb !== {6'h3F, 16'h0000, 16'hFFFF}) begin
         errors++; $display("FAIL io_oeb: got %h expected %h", io_oeb, {6'h3F, 16'h0000, 16'hFFFF});
      end
   endtask

   task automatic test_handshake();
      logic [31:0] r;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = A_COUNT; wbs_dat_i = 32'hAB60; wbs_sel_i = 4'hF;
      #3;
      checks++;
      if (wbs_ack_o !== 1'b0) begin
         errors++; $display("FAIL ack_early: got %b expected 0", wbs_ack_o);
      end
      @(posedge wb_clk_i); #1;
      checks++;
      if (wbs_ack_o !== 1'b1) begin
         errors++; $display("FAIL ack_cycle: got %b expected 1", wbs_ack_o);
      end
      // stb stays high through the ack cycle: ack must still drop
      @(posedge wb_clk_i); #1;
      checks++;
      if (wbs_ack_o !== 1'b0) begin
         errors++; $display("FAIL ack_drop: got %b expected 0", wbs_ack_o);
      end
      bus_idle();
      @(posedge wb_clk_i); #1;
      checks++;
      if (io_out[31:16] !== 16'hAB60) begin
         errors++; $display("FAIL io_out_count: got %h expected ab60", io_out[31:16]);
      end
      wb_read(A_COUNT, r);
      checks++;
      if (r !== 32'h0000AB60) begin
         errors++; $display("FAIL count_read: got %h expected 0000ab60", r);
      end
      begin
         logic ak; logic [31:0] d;
         wb_access(A_COUNT, 32'hFFFF_FF61, 4'b0001, 1'b1, ak, d);
         wb_access(A_RELOAD, 32'h1255_3377, 4'b0100, 1'b1, ak, d);
      end
      wb_read(A_COUNT, r);
      checks++;
      if (r !== 32'h0000AB61) begin
         errors++; $display("FAIL byte_write_b0: got %h expected 0000ab61", r);
      end
      wb_read(A_RELOAD, r);
      checks++;
      if (r !== 32'h0055_0000) begin
         errors++; $display("FAIL byte_write_b2: got %h expected 00550000", r);
      end
   endtask

   task automatic test_up_count();
      logic [31:0] r;
      wb_write(A_CTRL, 32'h0);
      wb_write(A_STATUS, 32'h1);
      wb_write(A_RELOAD, 32'd5);
      wb_write(A_COUNT, 32'd0);
      wb_write(A_CTRL, 32'h9);
      // one step has already happened when the write returns
      for (int j = 1; j <= 10; j++) begin
         checks++;
         if (io_out[31:16] !== 16'((j < 5) ? j : 5)) begin
            errors++; $display("FAIL up_seq[%0d]: got %0d expected %0d", j, io_out[31:16], (j < 5) ? j : 5);
         end
         @(posedge wb_clk_i); #1;
      end
      checks++;
      if (irq !== 3'b001) begin
         errors++; $display("FAIL up_irq: got %b expected 001", irq);
      end
      wb_read(A_CTRL, r);
      checks++;
      if (r !== 32'h8) begin
         errors++; $display("FAIL up_en_clear: got %h expected 00000008", r);
      end
      wb_read(A_STATUS, r);
      checks++;
      if (r !== 32'h1) begin
         errors++; $display("FAIL up_match: got %h expected 00000001", r);
      end
   endtask

   task automatic test_down_reload();
      logic [31:0] r;
      int exp;
      wb_write(A_CTRL, 32'h0);
      wb_write(A_STATUS, 32'h1);
      wb_write(A_RELOAD, 32'd3);
      wb_write(A_COUNT, 32'd1);
      wb_write(A_CTRL, 32'h7);
      // period RELOAD+1 = 4, starting from 1 and already one step in
      for (int j = 1; j <= 9; j++) begin
         exp = (((1 - j) % 4) + 4) % 4;
         checks++;
         if (io_out[31:16] !== 16'(exp)) begin
            errors++; $display("FAIL down_seq[%0d]: got %0d expected %0d", j, io_out[31:16], exp);
         end
         @(posedge wb_clk_i); #1;
      end
      checks++;
      if (irq !== 3'b000) begin
         errors++; $display("FAIL down_irq_masked: got %b expected 000", irq);
      end
      wb_read(A_STATUS, r);
      checks++;
      if (r !== 32'h1) begin
         errors++; $display("FAIL down_match: got %h expected 00000001", r);
      end
   endtask

   task automatic test_w1c_vs_set();
      logic ak; logic [31:0] r;
      wb_write(A_CTRL, 32'h0);
      wb_write(A_STATUS, 32'h1);
      wb_write(A_RELOAD, 32'd4);
      wb_write(A_COUNT, 32'd0);
      wb_write(A_CTRL, 32'hD);
      // count hits 4 five steps after the CTRL write edge; aim the W1C at it
      repeat (3) begin @(posedge wb_clk_i); #1; end
      wb_access(A_STATUS, 32'h1, 4'h1, 1'b1, ak, r);
      checks++;
      if (irq !== 3'b001) begin
         errors++; $display("FAIL set_beats_w1c: irq got %b expected 001", irq);
      end
      wb_write(A_CTRL, 32'h8);
      wb_write(A_STATUS, 32'h1);
      checks++;
      if (irq !== 3'b000) begin
         errors++; $display("FAIL w1c_irq: got %b expected 000", irq);
      end
      wb_read(A_STATUS, r);
      checks++;
      if (r !== 32'h0) begin
         errors++; $display("FAIL w1c_status: got %h expected 00000000", r);
      end
   endtask

   task automatic test_addr_miss();
      logic [31:0] snap [4];
      logic [31:0] r;
      for (int i = 0; i < 4; i++) snap[i] = m_read(2'(i));
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = 32'h3000_0010; wbs_dat_i = 32'hFFFF_FFFF; wbs_sel_i = 4'hF;
      for (int c = 0; c < 10; c++) begin
         @(posedge wb_clk_i); #1;
         checks++;
         if (wbs_ack_o !== 1'b0) begin
            errors++; $display("FAIL miss_ack[%0d]: got %b expected 0", c, wbs_ack_o);
         end
      end
      bus_idle();
      for (int i = 0; i < 4; i++) begin
         wb_read(BASE + 32'(4 * i), r);
         checks++;
         if (r !== snap[i]) begin
            errors++; $display("FAIL miss_reg%0d: got %h expected %h", i, r, snap[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] idx;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) < 5) begin
            idx = 2'($urandom_range(0, 3));
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
            wbs_we_i  = 1'($urandom_range(0, 1));
            wbs_adr_i = BASE | {26'd0, idx, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) wbs_adr_i = wbs_adr_i ^ (32'h10 << $urandom_range(0, 27));
            wbs_sel_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ((idx == 2'd1 || idx == 2'd2) && $urandom_range(0, 7) != 0)
               wbs_dat_i = 32'($urandom_range(0, 7));
            else
               wbs_dat_i = $urandom;
         end else begin
            bus_idle();
            wbs_cyc_i = 1'($urandom_range(0, 1));
         end
         @(posedge wb_clk_i); #1;
         checks++;
         if (wbs_ack_o !== m_busy || wbs_dat_o !== m_dat) begin
            errors++;
            $display("FAIL rnd_bus[%0d]: ack=%b dat=%h expected ack=%b dat=%h", i, wbs_ack_o, wbs_dat_o, m_busy, m_dat);
         end
         checks++;
         if (io_out !== {6'b0, m_count[15:0], 16'b0} || irq !== {2'b00, m_match & m_ctrl[3]}) begin
            errors++;
            $display("FAIL rnd_out[%0d]: io_out=%h irq=%b expected io_out=%h irq=%b", i, io_out, irq,
                     {6'b0, m_count[15:0], 16'b0}, {2'b00, m_match & m_ctrl[3]});
         end
      end
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_up_count();
      test_down_reload();
      test_w1c_vs_set();
      test_addr_miss();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
